uart_row_sender: RTL and testbench
==================================

// Module: uart_row_sender
// PURPOSE
//  Initiator side of the uart2vga row-upload protocol; the uart2vga_with_answer responder is the other end.
//  Sends one row packet: Y low byte, Y high byte, ROW_BYTES pixel bytes, END_WORD.
//  Checks the per-byte answer codes and retries incomplete packets.
//  Drives an external uart_transmiter (start_strobe/data/busy) and consumes an external uart_receiver (data/done).
//  Used for board-to-board links and as the synthesizable stimulus engine for uart2vga benches.
// PARAMETERS
//  ROW_BYTES       240     pixel bytes per packet
//  ANSWER_TIMEOUT  20000   clk cycles allowed from tx_start to the expected answer byte
//  MAX_RETRY       3       packet re-sends after NOT_ALL_RECEIVED
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  start      in   1   one-cycle pulse: send packet; ignored while busy=1
//  row_y      in   16  row number; sampled when start is accepted
//  rd_addr    out  8   pixel index into the row buffer
//  rd_data    in   8   buffer data; valid one clk after rd_addr (synchronous RAM)
//  tx_start   out  1   one-cycle pulse to uart_transmiter.start_strobe
//  tx_data    out  8   byte to uart_transmiter.data; held stable while tx_busy=1
//  tx_busy    in   1   uart_transmiter.busy
//  rx_data    in   8   uart_receiver.data
//  rx_done    in   1   one-cycle pulse: rx_data valid
//  busy       out  1   packet in progress
//  done       out  1   one-cycle pulse at packet end, success or failure
//  ok         out  1   result of last packet; valid from done, held until next start
//  err_code   out  2   0 none, 1 timeout, 2 bad answer, 3 incomplete after retries
//  missing    out  8   byte count reported with the last NOT_ALL_RECEIVED
// BEHAVIOUR
//  Reset values: all outputs 0 and state IDLE. Reset mid-packet aborts silently, with no done pulse.
//  Codes: ACK_Y=8'hCC, ACK_D=8'hAA, END_WORD=8'hDD, SUCCESS=8'hFF, NOT_ALL=8'h11.
//  Packet byte order:
//    idx0 = row_y[7:0], idx1 = row_y[15:8];
//    idx2..ROW_BYTES+1 = pixel 0..ROW_BYTES-1;
//    idx ROW_BYTES+2 = END_WORD.
//  FSM states: IDLE, SEND_Y, WAIT_Y, FETCH, SEND_D, WAIT_D, SEND_END, WAIT_FIN, WAIT_MISS, FINISH.
//  IDLE -> SEND_Y on start:
//    latch row_y; clear ok, err_code and missing; retry_cnt=0; busy=1 in the next cycle.
//  SEND_*: one send per byte.
//    Requires tx_busy=0; sets tx_data and pulses tx_start for exactly 1 clk.
//    Loads the timeout counter to ANSWER_TIMEOUT.
//  WAIT_*: one answer per byte.
//    Waits for an rx_done pulse; no new tx_start is issued until it arrives.
//    The counter decrements every clk; reaching 0 with no rx_done -> FINISH with err_code=1.
//    WAIT_Y: rx_data must be ACK_Y. After idx0 go to SEND_Y; after idx1 go to FETCH with pix=0.
//    FETCH: rd_addr=pix for one clk, then SEND_D takes rd_data. Latency: 2 clk from the ack to tx_start.
//    WAIT_D: rx_data must be ACK_D.
//      pix<ROW_BYTES-1: pix++ and go to FETCH.
//      pix=ROW_BYTES-1: go to SEND_END.
//    WAIT_FIN:
//      SUCCESS -> FINISH with ok=1.
//      NOT_ALL -> WAIT_MISS.
//    WAIT_MISS: the next rx_done byte goes to missing. Then:
//      retry_cnt<MAX_RETRY: retry_cnt++ and restart at SEND_Y, idx0.
//      otherwise: FINISH with err_code=3.
//    Any other code in any WAIT_* state -> FINISH with err_code=2.
//  FINISH: done=1 for 1 clk; busy=0 in the same clk; return to IDLE.
//  Simultaneous events:
//    rx_done on the same clk the timeout reaches 0: rx_done wins.
//    rx_done outside a WAIT_* state: ignored.
//    start while busy: ignored.
//  Widths: pix is 8 bits, so ROW_BYTES<=256. Timeout counter is $clog2(ANSWER_TIMEOUT+1) bits.
//  retry_cnt is $clog2(MAX_RETRY+1) bits and saturates.
// STRUCTURE
//  uart2vga_pkg: protocol codes, ROW_BYTES default, Y byte count, state_t enum, err_t enum.
//    Shared with uart2vga_with_answer.
//  One sub-module, answer_timer (load/decrement/expire), also reusable on the responder side.
//  Everything else is a single FSM with registered outputs.
// TESTING
//  Loop back against uart2vga_with_answer plus uart_transmiter/uart_receiver. Settings: 115200 baud, 2 stop bits, 50 MHz.
//  1. start, row_y=16'h2210:
//     bytes on the line are 10,22,buf[0..239],DD;
//     answers are CC,CC,AA x240, then FF; done=1, ok=1, err_code=0.
//  2. Responder model drops pixel 5's answer:
//     timeout fires ANSWER_TIMEOUT clk after that tx_start; done pulse, ok=0, err_code=1.
//  3. Model answers 8'h55 instead of CC to idx0: done, err_code=2, no further tx_start.
//  4. Model answers 11,03 then FF:
//     missing=3; a full second packet is resent with Y bytes first; ok=1.
//  5. Model always answers 11,01:
//     MAX_RETRY+1 = 4 packets sent, then err_code=3, missing=1.
//  6. rst_n low during pixel 100: all outputs 0 within 1 clk, no done;
//     a new start then sends a clean packet.

Source files
------------

// File: rtl/uart2vga_pkg.sv
// rtl/uart2vga_pkg.sv - uart2vga row-upload protocol codes, states and error codes
// Shared by the row sender (initiator) and the uart2vga_with_answer responder.
package uart2vga_pkg;

   localparam logic [7:0] ACK_Y    = 8'hCC;
   localparam logic [7:0] ACK_D    = 8'hAA;
   localparam logic [7:0] END_WORD = 8'hDD;
   localparam logic [7:0] SUCCESS  = 8'hFF;
   localparam logic [7:0] NOT_ALL  = 8'h11;

   localparam int ROW_BYTES_DEF = 240;
   localparam int Y_BYTES       = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_Y,
      ST_WAIT_Y,
      ST_FETCH,
      ST_SEND_D,
      ST_WAIT_D,
      ST_SEND_END,
      ST_WAIT_FIN,
      ST_WAIT_MISS,
      ST_FINISH
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_TIMEOUT    = 2'd1,
      ERR_BAD        = 2'd2,
      ERR_INCOMPLETE = 2'd3
   } err_t;

endpackage

// File: rtl/answer_timer.sv
// rtl/answer_timer.sv - answer timeout counter: load, decrement, expire
// o_expired is raised on the clk the count would reach zero, so the owner reacts exactly TIMEOUT clk after load.
module answer_timer #(
   parameter int TIMEOUT = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_run,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(TIMEOUT);
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_expired = (r_cnt <= CW'(1));

endmodule

// File: rtl/uart_row_sender.sv
// rtl/uart_row_sender.sv - initiator of the uart2vga row upload: sends Y, pixels, END_WORD
// Every byte is acknowledged by the responder; NOT_ALL_RECEIVED triggers a bounded packet resend.
module uart_row_sender
   import uart2vga_pkg::*;
#(
   parameter int ROW_BYTES      = ROW_BYTES_DEF,
   parameter int ANSWER_TIMEOUT = 20000,
   parameter int MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] row_y,
   output logic [7:0]  rd_addr,
   input  logic [7:0]  rd_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic        busy,
   output logic        done,
   output logic        ok,
   output logic [1:0]  err_code,
   output logic [7:0]  missing
);

   localparam int              RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [7:0]      PIX_LAST  = 8'(ROW_BYTES - 1);
   localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
   localparam logic            Y_LAST    = 1'(Y_BYTES - 1);

   state_t        r_state,   w_state_nx;
   logic [15:0]   r_y,       w_y_nx;
   logic          r_y_idx,   w_y_idx_nx;
   logic [7:0]    r_pix,     w_pix_nx;
   logic [RW-1:0] r_retry,   w_retry_nx;
   logic [7:0]    r_rd_addr, w_rd_addr_nx;
   logic          r_tx_start, w_tx_start_nx;
   logic [7:0]    r_tx_data, w_tx_data_nx;
   logic          r_busy,    w_busy_nx;
   logic          r_done,    w_done_nx;
   logic          r_ok,      w_ok_nx;
   logic [1:0]    r_err,     w_err_nx;
   logic [7:0]    r_missing, w_missing_nx;

   logic          w_tmr_load;
   logic          w_tmr_run;
   logic          w_tmr_expired;
   logic          w_fin;
   logic          w_fin_ok;
   err_t          w_fin_err;

   answer_timer #(
      .TIMEOUT (ANSWER_TIMEOUT)
   ) u_answer_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_tmr_load),
      .i_run     (w_tmr_run),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_y        <= '0;
         r_y_idx    <= 1'b0;
         r_pix      <= '0;
         r_retry    <= '0;
         r_rd_addr  <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= '0;
         r_missing  <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_y        <= w_y_nx;
         r_y_idx    <= w_y_idx_nx;
         r_pix      <= w_pix_nx;
         r_retry    <= w_retry_nx;
         r_rd_addr  <= w_rd_addr_nx;
         r_tx_start <= w_tx_start_nx;
         r_tx_data  <= w_tx_data_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_ok       <= w_ok_nx;
         r_err      <= w_err_nx;
         r_missing  <= w_missing_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_y_nx        = r_y;
      w_y_idx_nx    = r_y_idx;
      w_pix_nx      = r_pix;
      w_retry_nx    = r_retry;
      w_rd_addr_nx  = r_rd_addr;
      w_tx_start_nx = 1'b0;
      w_tx_data_nx  = r_tx_data;
      w_busy_nx     = r_busy;
      w_done_nx     = 1'b0;
      w_ok_nx       = r_ok;
      w_err_nx      = r_err;
      w_missing_nx  = r_missing;
      w_tmr_load    = 1'b0;
      w_tmr_run     = 1'b0;
      w_fin         = 1'b0;
      w_fin_ok      = 1'b0;
      w_fin_err     = ERR_NONE;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nx   = ST_SEND_Y;
               w_y_nx       = row_y;
               w_y_idx_nx   = 1'b0;
               w_retry_nx   = '0;
               w_ok_nx      = 1'b0;
               w_err_nx     = ERR_NONE;
               w_missing_nx = '0;
               w_busy_nx    = 1'b1;
            end
         end

         ST_SEND_Y: begin
            if (!tx_busy) begin
               w_tx_start_nx = 1'b1;
               w_tx_data_nx  = r_y_idx ? r_y[15:8] : r_y[7:0];
               w_tmr_load    = 1'b1;
               w_state_nx    = ST_WAIT_Y;
            end
         end

         ST_WAIT_Y: begin
            w_tmr_run = 1'b1;
            if (rx_done) begin
               if (rx_data != ACK_Y) begin
                  w_fin     = 1'b1;
                  w_fin_err = ERR_BAD;
               end else if (r_y_idx == Y_LAST) begin
                  w_pix_nx     = '0;
                  w_rd_addr_nx = '0;
                  w_state_nx   = ST_FETCH;
               end else begin
                  w_y_idx_nx = 1'b1;
                  w_state_nx = ST_SEND_Y;
               end
            end else if (w_tmr_expired) begin
               w_fin     = 1'b1;
               w_fin_err = ERR_TIMEOUT;
            end
         end

         // rd_addr is already registered here; the RAM output is valid in SEND_D.
         ST_FETCH: begin
            w_state_nx = ST_SEND_D;
         end

         ST_SEND_D: begin
            if (!tx_busy) begin
               w_tx_start_nx = 1'b1;
               w_tx_data_nx  = rd_data;
               w_tmr_load    = 1'b1;
               w_state_nx    = ST_WAIT_D;
            end
         end

         ST_WAIT_D: begin
            w_tmr_run = 1'b1;
            if (rx_done) begin
               if (rx_data != ACK_D) begin
                  w_fin     = 1'b1;
                  w_fin_err = ERR_BAD;
               end else if (r_pix == PIX_LAST) begin
                  w_state_nx = ST_SEND_END;
               end else begin
                  w_pix_nx     = r_pix + 8'd1;
                  w_rd_addr_nx = r_pix + 8'd1;
                  w_state_nx   = ST_FETCH;
               end
            end else if (w_tmr_expired) begin
               w_fin     = 1'b1;
               w_fin_err = ERR_TIMEOUT;
            end
         end

         ST_SEND_END: begin
            if (!tx_busy) begin
               w_tx_start_nx = 1'b1;
               w_tx_data_nx  = END_WORD;
               w_tmr_load    = 1'b1;
               w_state_nx    = ST_WAIT_FIN;
            end
         end

         ST_WAIT_FIN: begin
            w_tmr_run = 1'b1;
            if (rx_done) begin
               if (rx_data == SUCCESS) begin
                  w_fin    = 1'b1;
                  w_fin_ok = 1'b1;
               end else if (rx_data == NOT_ALL) begin
                  w_state_nx = ST_WAIT_MISS;
               end else begin
                  w_fin     = 1'b1;
                  w_fin_err = ERR_BAD;
               end
            end else if (w_tmr_expired) begin
               w_fin     = 1'b1;
               w_fin_err = ERR_TIMEOUT;
            end
         end

         // The count byte follows NOT_ALL without a new send, so the running timer still covers it.
         ST_WAIT_MISS: begin
            w_tmr_run = 1'b1;
            if (rx_done) begin
               w_missing_nx = rx_data;
               if (r_retry < RETRY_MAX) begin
                  w_retry_nx = r_retry + RW'(1);
                  w_y_idx_nx = 1'b0;
                  w_state_nx = ST_SEND_Y;
               end else begin
                  w_fin     = 1'b1;
                  w_fin_err = ERR_INCOMPLETE;
               end
            end else if (w_tmr_expired) begin
               w_fin     = 1'b1;
               w_fin_err = ERR_TIMEOUT;
            end
         end

         ST_FINISH: begin
            w_state_nx = ST_IDLE;
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_busy_nx  = 1'b0;
         end
      endcase

      if (w_fin) begin
         w_state_nx = ST_FINISH;
         w_done_nx  = 1'b1;
         w_busy_nx  = 1'b0;
         w_ok_nx    = w_fin_ok;
         w_err_nx   = w_fin_err;
      end
   end

   assign rd_addr  = r_rd_addr;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign busy     = r_busy;
   assign done     = r_done;
   assign ok       = r_ok;
   assign err_code = r_err;
   assign missing  = r_missing;

endmodule

// File: tb/tb_uart_row_sender.sv
// tb/tb_uart_row_sender.sv - table-driven bench for uart_row_sender with a responder model
module tb_uart_row_sender;

   localparam int R   = 4;
   localparam int AT  = 40;
   localparam int MR  = 3;

   localparam int M_NORMAL   = 0;
   localparam int M_DROP     = 1;
   localparam int M_BAD_Y0   = 2;
   localparam int M_NA_ONCE  = 3;
   localparam int M_NA_ALWAY = 4;
   localparam int M_BAD_FIN  = 5;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] row_y;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        busy;
   logic        done;
   logic        ok;
   logic [1:0]  err_code;
   logic [7:0]  missing;

   uart_row_sender #(
      .ROW_BYTES      (R),
      .ANSWER_TIMEOUT (AT),
      .MAX_RETRY      (MR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .row_y    (row_y),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .busy     (busy),
      .done     (done),
      .ok       (ok),
      .err_code (err_code),
      .missing  (missing)
   );

   typedef struct {
      logic [15:0] y;
      int          mode;
      int          param;
      logic        poke;
      logic        exp_ok;
      logic [1:0]  exp_err;
      logic [7:0]  exp_miss;
      int          exp_bytes;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  mem [256];

   logic [15:0] cur_y;
   int          cur_mode;
   int          cur_param;
   int          pos;
   int          pkt_no;
   int          n_bytes;
   int          last_tx_cyc;
   int          done_cyc;
   logic [7:0]  resp_b;
   logic [7:0]  resp_exp;
   logic [7:0]  resp_ans;
   bit          resp_silent;
   bit          resp_two;
   logic [7:0]  hold_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pulse_start(input logic [15:0] y);
      row_y = y;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit got);
      got = 0;
      for (int k = 0; k < 5000; k++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1;
            done_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_done"},     done,     0);
      check({tag, "_ok"},       ok,       0);
      check({tag, "_err"},      err_code, 0);
      check({tag, "_missing"},  missing,  0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_tx_data"},  tx_data,  0);
      check({tag, "_rd_addr"},  rd_addr,  0);
   endtask

   // Transmitter model: busy for 4 clk after each start; tx_data must not move meanwhile.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start) begin
            hold_data = tx_data;
            tx_busy = 1'b1;
            repeat (4) begin
               @(posedge clk); #1;
               if (rst_n) check("tx_data_hold", tx_data, hold_data);
            end
            tx_busy = 1'b0;
         end
      end
   end

   // Responder model: checks each line byte and answers according to cur_mode.
   initial begin
      rx_done = 1'b0;
      rx_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst_n && tx_start) begin
            resp_b = tx_data;
            n_bytes++;
            last_tx_cyc = cyc;
            resp_silent = 0;
            resp_two = 0;
            if (pos == 0) resp_exp = cur_y[7:0];
            else if (pos == 1) resp_exp = cur_y[15:8];
            else if (pos <= R + 1) resp_exp = mem[pos - 2];
            else resp_exp = 8'hDD;
            check("stream_byte", resp_b, resp_exp);
            if (pos <= 1) begin
               resp_ans = (cur_mode == M_BAD_Y0 && pos == 0) ? 8'h55 : 8'hCC;
            end else if (pos <= R + 1) begin
               resp_ans = 8'hAA;
               if (cur_mode == M_DROP && pkt_no == 0 && (pos - 2) == cur_param) resp_silent = 1;
            end else begin
               resp_ans = 8'hFF;
               if (cur_mode == M_BAD_FIN) resp_ans = 8'h42;
               if (cur_mode == M_NA_ALWAY || (cur_mode == M_NA_ONCE && pkt_no == 0)) begin
                  resp_ans = 8'h11;
                  resp_two = 1;
               end
            end
            if (pos == R + 2) begin
               pos = 0;
               pkt_no++;
            end else begin
               pos++;
            end
            if (!resp_silent) begin
               repeat (2) @(posedge clk);
               #1;
               rx_data = resp_ans;
               rx_done = 1'b1;
               @(posedge clk); #1;
               rx_done = 1'b0;
               if (resp_two) begin
                  repeat (3) @(posedge clk);
                  #1;
                  rx_data = 8'(cur_param);
                  rx_done = 1'b1;
                  @(posedge clk); #1;
                  rx_done = 1'b0;
               end
            end
         end
      end
   end

   vec_t vecs [6];

   initial begin
      vec_t v;
      bit   got;
      int   seen_done;

      vecs[0] = '{16'h2210, M_NORMAL,   0, 1'b1, 1'b1, 2'd0, 8'd0, R + 3};
      vecs[1] = '{16'h0005, M_DROP,     2, 1'b0, 1'b0, 2'd1, 8'd0, 5};
      vecs[2] = '{16'h1234, M_BAD_Y0,   0, 1'b0, 1'b0, 2'd2, 8'd0, 1};
      vecs[3] = '{16'hA55A, M_NA_ONCE,  3, 1'b0, 1'b1, 2'd0, 8'd3, 2 * (R + 3)};
      vecs[4] = '{16'h00FF, M_NA_ALWAY, 1, 1'b0, 1'b0, 2'd3, 8'd1, (MR + 1) * (R + 3)};
      vecs[5] = '{16'h7E01, M_BAD_FIN,  0, 1'b0, 1'b0, 2'd2, 8'd0, R + 3};

      for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37) ^ 8'hA5);
      rst_n = 1'b0;
      start = 1'b0;
      row_y = 16'h0000;
      cur_y = 16'h0000;
      cur_mode = M_NORMAL;
      cur_param = 0;
      pos = 0;
      pkt_no = 0;
      n_bytes = 0;
      last_tx_cyc = 0;
      done_cyc = 0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         cur_y = v.y;
         cur_mode = v.mode;
         cur_param = v.param;
         pos = 0;
         pkt_no = 0;
         n_bytes = 0;
         pulse_start(v.y);
         row_y = 16'hFFFF;
         check("busy_after_start", busy, 1);
         if (v.poke) begin
            repeat (3) @(posedge clk);
            #1;
            pulse_start(~v.y);
            check("busy_after_ignored_start", busy, 1);
         end
         wait_done(got);
         check("done_seen", 32'(got), 1);
         check("ok", ok, v.exp_ok);
         check("err_code", err_code, v.exp_err);
         check("missing", missing, v.exp_miss);
         check("busy_at_done", busy, 0);
         check("bytes_sent", n_bytes, v.exp_bytes);
         if (v.mode == M_DROP) check("timeout_latency", done_cyc - last_tx_cyc, AT);
         @(posedge clk); #1;
         check("done_one_clk", done, 0);
         check("ok_held", ok, v.exp_ok);
         repeat (10) @(posedge clk);
         #1;
         check("no_tx_after_done", n_bytes, v.exp_bytes);
      end

      // Reset in the middle of pixel 2: silent abort, then a clean packet.
      cur_y = 16'h0BEE;
      cur_mode = M_NORMAL;
      pos = 0;
      pkt_no = 0;
      n_bytes = 0;
      pulse_start(16'h0BEE);
      for (int k = 0; k < 2000 && n_bytes < 5; k++) begin
         @(posedge clk); #1;
      end
      check("reached_pixel2", n_bytes, 5);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      seen_done = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      check("no_done_on_reset", seen_done, 0);

      cur_y = 16'h3C4D;
      pos = 0;
      pkt_no = 0;
      n_bytes = 0;
      pulse_start(16'h3C4D);
      wait_done(got);
      check("post_reset_done", 32'(got), 1);
      check("post_reset_ok", ok, 1);
      check("post_reset_err", err_code, 0);
      check("post_reset_bytes", n_bytes, R + 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
